// File: rtl/uart_seq_trig_if.sv
// uart_seq_trig_if: bundles the serial input, configuration and trigger
//   outputs of uart_seq_trig so the trigger block and its driver share one port.
// Ports (signals):
//   RX        serial line, idle high, asynchronous to clk
//   baud_cnt  clocks per bit (values below 2 act as 2)
//   match     pattern, newest word in the low DATA_W bits
//   mask      1 = don't-care bit
//   armed     1 = trigger enabled, 0 = history and sticky flag cleared
//   trig      one-cycle pulse on pattern match
//   trig_hold sticky copy of trig
//   frame_err one-cycle pulse on a bad stop bit
//   par_err   one-cycle pulse on a parity error
interface uart_seq_trig_if #(
  parameter int DATA_W  = 8,
  parameter int SEQ_LEN = 2,
  parameter int BAUD_W  = 16
);
  logic                      RX;
  logic [BAUD_W-1:0]         baud_cnt;
  logic [SEQ_LEN*DATA_W-1:0] match;
  logic [SEQ_LEN*DATA_W-1:0] mask;
  logic                      armed;
  logic                      trig;
  logic                      trig_hold;
  logic                      frame_err;
  logic                      par_err;

  // Driver side (stimulus / capture front end).
  modport master (
    output RX, baud_cnt, match, mask, armed,
    input  trig, trig_hold, frame_err, par_err
  );

  // Trigger block side.
  modport slave (
    input  RX, baud_cnt, match, mask, armed,
    output trig, trig_hold, frame_err, par_err
  );
endinterface

// File: rtl/uart_seq_trig.sv
// uart_seq_trig: oversampling UART receiver that keeps the last SEQ_LEN words
//   and pulses trig when that history matches a masked multi-word pattern.
// Latency: 2 clk synchroniser; trig/frame_err registered 1 clk after the stop
//   sample strobe. No backpressure: RX cannot be stalled, every frame is taken.
// Ports: clk, rst (async, active high); bus (uart_seq_trig_if.slave) carries
//   RX, baud_cnt, match, mask, armed in and trig, trig_hold, frame_err,
//   par_err out.
// Build option: define UART_SEQ_TRIG_PARITY_EN to receive one even-parity bit
//   after the data bits; otherwise par_err is tied low.
module uart_seq_trig #(
  parameter int DATA_W  = 8,
  parameter int SEQ_LEN = 2,
  parameter int BAUD_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_seq_trig_if.slave bus
);
  localparam int HW = SEQ_LEN * DATA_W;
  localparam int VW = $clog2(SEQ_LEN + 1);
  localparam int IW = 4;

`ifdef UART_SEQ_TRIG_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            r_state, w_state_nxt;
  logic              r_sync1, r_sync2;
  logic              w_rxs;
  logic [BAUD_W-1:0] r_bcnt, w_bcnt_nxt;
  logic [BAUD_W-1:0] w_p, w_half_m1, w_reload;
  logic [IW-1:0]     r_bidx, w_bidx_nxt;
  logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
  logic [HW-1:0]     r_hist, w_hist_nxt, w_hist_shift;
  logic [VW-1:0]     r_vcnt, w_vcnt_nxt, w_vcnt_inc;
  logic              r_trig, w_trig_nxt;
  logic              r_hold, w_hold_nxt;
  logic              r_ferr, w_ferr_nxt;
  logic              w_strobe, w_hit, w_word_ok;
`ifdef UART_SEQ_TRIG_PARITY_EN
  logic              r_perr, w_perr_nxt;
  logic              r_par_bad, w_par_bad_nxt;
  assign w_word_ok = ~r_par_bad;
`else
  assign w_word_ok = 1'b1;
`endif

  assign w_rxs     = r_sync2;
  assign w_p       = (bus.baud_cnt < BAUD_W'(2)) ? BAUD_W'(2) : bus.baud_cnt;
  assign w_half_m1 = (w_p >> 1) - BAUD_W'(1);
  assign w_reload  = w_p - BAUD_W'(1);
  assign w_strobe  = (r_bcnt == '0);

  // Match is judged on the history as it will be after this word is taken.
  assign w_hist_shift = (r_hist << DATA_W) | HW'(r_shreg);
  assign w_vcnt_inc   = (r_vcnt == VW'(SEQ_LEN)) ? r_vcnt : r_vcnt + VW'(1);
  assign w_hit        = (w_vcnt_inc == VW'(SEQ_LEN)) &&
                        (((w_hist_shift ^ bus.match) & ~bus.mask) == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_bidx_nxt  = r_bidx;
    w_shreg_nxt = r_shreg;
    w_hist_nxt  = r_hist;
    w_vcnt_nxt  = r_vcnt;
    w_trig_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef UART_SEQ_TRIG_PARITY_EN
    w_perr_nxt    = 1'b0;
    w_par_bad_nxt = r_par_bad;
`endif
    // Any counter value reaches 0 in bounded time, so a baud change
    // mid-frame can only garble the frame, never stall the FSM.
    if (r_state != IDLE)
      w_bcnt_nxt = w_strobe ? w_reload : r_bcnt - BAUD_W'(1);

    case (r_state)
      IDLE: begin
        if (!w_rxs) begin
          w_bcnt_nxt  = w_half_m1;   // land the start sample mid-bit
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_strobe) begin
          if (!w_rxs) begin
            w_state_nxt = DATA;
            w_bidx_nxt  = '0;
          end else begin
            w_state_nxt = IDLE;      // glitch, not a start bit
          end
        end
      end
      DATA: begin
        if (w_strobe) begin
          w_shreg_nxt = {w_rxs, r_shreg[DATA_W-1:1]};   // LSB first
          w_bidx_nxt  = r_bidx + IW'(1);
          if (r_bidx == IW'(DATA_W - 1)) begin
`ifdef UART_SEQ_TRIG_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_SEQ_TRIG_PARITY_EN
      PARITY: begin
        if (w_strobe) begin
          // Even parity: data plus parity bit must hold an even count of 1s.
          w_par_bad_nxt = ^{r_shreg, w_rxs};
          w_perr_nxt    = ^{r_shreg, w_rxs};
          w_state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        if (w_strobe) begin
          w_state_nxt = IDLE;
          if (w_rxs) begin
            if (w_word_ok) begin
              w_hist_nxt = w_hist_shift;
              w_vcnt_nxt = w_vcnt_inc;
              w_trig_nxt = w_hit;
            end
          end else begin
            w_ferr_nxt = 1'b1;
            w_hist_nxt = '0;
            w_vcnt_nxt = '0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Disarmed: framing continues but nothing is remembered or reported.
    if (!bus.armed) begin
      w_hist_nxt = '0;
      w_vcnt_nxt = '0;
      w_trig_nxt = 1'b0;
    end
    w_hold_nxt = bus.armed & (r_hold | w_trig_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= IDLE;
      r_bcnt    <= '0;
      r_bidx    <= '0;
      r_shreg   <= '0;
      r_hist    <= '0;
      r_vcnt    <= '0;
      r_trig    <= 1'b0;
      r_hold    <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_SEQ_TRIG_PARITY_EN
      r_perr    <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_sync1   <= bus.RX;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_bidx    <= w_bidx_nxt;
      r_shreg   <= w_shreg_nxt;
      r_hist    <= w_hist_nxt;
      r_vcnt    <= w_vcnt_nxt;
      r_trig    <= w_trig_nxt;
      r_hold    <= w_hold_nxt;
      r_ferr    <= w_ferr_nxt;
`ifdef UART_SEQ_TRIG_PARITY_EN
      r_perr    <= w_perr_nxt;
      r_par_bad <= w_par_bad_nxt;
`endif
    end
  end

  assign bus.trig      = r_trig;
  assign bus.trig_hold = r_hold;
  assign bus.frame_err = r_ferr;
`ifdef UART_SEQ_TRIG_PARITY_EN
  assign bus.par_err   = r_perr;
`else
  assign bus.par_err   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_seq_trig.sv
// tb_uart_seq_trig: drives UART frames into uart_seq_trig, predicts every
//   trig / frame_err pulse (and its exact cycle) from a word-history model,
//   and a separate monitor matches each DUT pulse against that queue.
`timescale 1ns/1ps
module tb_uart_seq_trig;
  localparam int DATA_W  = 8;
  localparam int SEQ_LEN = 2;
  localparam int BAUD_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_seq_trig_if #(.DATA_W(DATA_W), .SEQ_LEN(SEQ_LEN), .BAUD_W(BAUD_W)) bus ();

  uart_seq_trig #(.DATA_W(DATA_W), .SEQ_LEN(SEQ_LEN), .BAUD_W(BAUD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  typedef struct {
    bit is_trig;
    int at;
  } ev_t;
  ev_t         exp_q[$];
  ev_t         mon_e;
  logic [7:0]  hist_m[$];   // newest word at index 0
  bit          hold_m, armed_m;
  logic [15:0] match_m, mask_m;

  task automatic check(input string name, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] m, input logic [15:0] k, input bit a);
    bus.match = m;
    bus.mask  = k;
    bus.armed = a;
    match_m   = m;
    mask_m    = k;
    armed_m   = a;
    if (!a) begin
      hist_m.delete();
      hold_m = 1'b0;
    end
  endtask

  // Predict the outcome of one frame from the word history.
  task automatic model_frame(input logic [7:0] d, input bit good, input int t);
    bit hit;
    if (!good) begin
      exp_q.push_back('{1'b0, t});
      hist_m.delete();
      return;
    end
    if (!armed_m) return;
    hist_m.push_front(d);
    if (hist_m.size() > SEQ_LEN) void'(hist_m.pop_back());
    hit = (hist_m.size() == SEQ_LEN);
    for (int j = 0; j < hist_m.size(); j++)
      if (((hist_m[j] ^ match_m[j*8 +: 8]) & ~mask_m[j*8 +: 8]) != 8'h00) hit = 1'b0;
    if (hit) begin
      exp_q.push_back('{1'b1, t});
      hold_m = 1'b1;
    end
  endtask

  // RX falls just after edge k; the synchroniser adds 2 clk, the start
  // sample lands P>>1 clk later and each following sample P clk later,
  // so the stop-sample result is visible at edge k+3+(P>>1)+(DATA_W+1)*P.
  task automatic send_frame(input logic [7:0] d, input bit good, input int bc, input int gap);
    int p, half, k;
    p    = (bc < 2) ? 2 : bc;
    half = p >> 1;
    bus.baud_cnt = BAUD_W'(bc);
    tick();
    k = cyc;
    model_frame(d, good, k + 3 + half + (DATA_W + 1) * p);
    bus.RX = 1'b0;
    repeat (p) tick();
    for (int i = 0; i < DATA_W; i++) begin
      bus.RX = d[i];
      repeat (p) tick();
    end
    if (good) begin
      bus.RX = 1'b1;
      repeat (p) tick();
    end else begin
      // Low only until past the stop sample so the line is idle again
      // by the time the receiver is back in IDLE.
      bus.RX = 1'b0;
      repeat (half + 1) tick();
      bus.RX = 1'b1;
      repeat (p) tick();
    end
    repeat (3 + gap) tick();
    check("trig_hold", bus.trig_hold, hold_m);
    check("par_err", bus.par_err, 0);
  endtask

  // Monitor: every pulse the DUT shows must be the next predicted one.
  always @(negedge clk) begin
    if (!rst && (bus.trig || bus.frame_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {bus.trig, bus.frame_err}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", {bus.trig, bus.frame_err}, {mon_e.is_trig, !mon_e.is_trig});
        check("pulse_cycle", cyc, mon_e.at);
        if (bus.trig) check("hold_with_trig", bus.trig_hold, 1);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int         bc, gap;
  logic [7:0] d;
  bit         good;
  int         bauds[8] = '{0, 1, 2, 3, 5, 8, 13, 16};
  logic [7:0] pool[4];

  initial begin
    bus.RX       = 1'b1;
    bus.baud_cnt = 16'd16;
    set_cfg(16'hA55A, 16'h0000, 1'b1);
    hold_m = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_trig", bus.trig, 0);
    check("rst_trig_hold", bus.trig_hold, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_par_err", bus.par_err, 0);
    rst = 1'b0;
    repeat (4) tick();

    // A5 then 5A completes the pattern.
    send_frame(8'hA5, 1'b1, 16, 2);
    send_frame(8'h5A, 1'b1, 16, 2);
    // 5A, A5 misses; a further 5A leaves history A5,5A and fires.
    send_frame(8'h5A, 1'b1, 16, 2);
    send_frame(8'hA5, 1'b1, 16, 2);
    send_frame(8'h5A, 1'b1, 16, 2);
    // Low word don't-care.
    set_cfg(16'hA500, 16'h00FF, 1'b1);
    send_frame(8'hA5, 1'b1, 16, 2);
    send_frame(8'h33, 1'b1, 16, 2);

    // Reset in the middle of a frame; the half-built history must vanish.
    set_cfg(16'hA55A, 16'h0000, 1'b1);
    send_frame(8'hA5, 1'b1, 16, 2);
    tick();
    bus.RX = 1'b0;
    repeat (16) tick();
    bus.RX = 1'b0;
    repeat (40) tick();
    rst    = 1'b1;
    bus.RX = 1'b1;
    tick();
    check("midrst_trig", bus.trig, 0);
    check("midrst_trig_hold", bus.trig_hold, 0);
    check("midrst_frame_err", bus.frame_err, 0);
    check("midrst_par_err", bus.par_err, 0);
    hist_m.delete();
    hold_m = 1'b0;
    rst = 1'b0;
    repeat (4) tick();
    send_frame(8'h5A, 1'b1, 16, 2);

    // Bad stop bit clears history, so the next 5A cannot complete A5,5A.
    send_frame(8'hA5, 1'b0, 16, 2);
    send_frame(8'h5A, 1'b1, 16, 2);

    // Short glitch: false start, then the receiver still frames correctly.
    bus.baud_cnt = 16'd16;
    tick();
    bus.RX = 1'b0;
    repeat (4) tick();
    bus.RX = 1'b1;
    repeat (40) tick();
    check("glitch_frame_err", bus.frame_err, 0);
    send_frame(8'hA5, 1'b1, 16, 2);
    send_frame(8'h5A, 1'b1, 16, 2);

    // Disarmed: no trig, sticky flag cleared.
    set_cfg(16'hA55A, 16'h0000, 1'b0);
    send_frame(8'hA5, 1'b1, 16, 2);
    send_frame(8'h5A, 1'b1, 16, 2);
    set_cfg(16'hA55A, 16'h0000, 1'b1);

    // Randomised frames, baud rates, patterns and arming.
    for (int n = 0; n < 90; n++) begin
      pool[0] = 8'hA5;
      pool[1] = 8'h5A;
      pool[2] = 8'h33;
      pool[3] = 8'($urandom);
      if ($urandom_range(0, 9) == 0)
        set_cfg({pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)]},
                ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000, 1'b1);
      if ($urandom_range(0, 11) == 0)
        set_cfg(match_m, mask_m, !armed_m);
      d    = pool[$urandom_range(0, 3)];
      good = ($urandom_range(0, 7) != 0);
      bc   = bauds[$urandom_range(0, 7)];
      gap  = $urandom_range(0, 5);
      send_frame(d, good, bc, gap);
    end

    repeat (50) tick();
    check("pending_pulses", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
